// File: rtl/rx_pkg.sv
// Shared definitions for the serial-frame receiver.
//   FRAME_BITS : payload width per frame (55)
//   CNT_W      : width of the bit down-counter
//   IDLE_LEVEL : level of the idle serial line (also the good stop level)
//   rx_state_t : receiver FSM state encoding
//   parity_step: one step of the running even-parity accumulator
package rx_pkg;

  localparam int   FRAME_BITS = 55;
  localparam int   CNT_W      = 6;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

  function automatic logic parity_step(input logic par, input logic bit_in);
    return par ^ bit_in;
  endfunction

endpackage

// File: rtl/receiver_if.sv
// Serial input and consumer handshake of the receiver.
//   S_Data        : serial line (idles high)
//   RX_Ack        : consumer accepts RX_Data
//   RX_Data       : last good payload, RX_Data[54] received first
//   RX_Data_Valid : RX_Data unconsumed
//   RX_Frame_Err  : one-cycle pulse on bad stop / bad parity
//   RX_Overrun    : one-cycle pulse when a good frame is dropped
// Modports: master = receiver side, slave = line driver / consumer side.
interface receiver_if;
  import rx_pkg::*;

  logic                  S_Data;
  logic                  RX_Ack;
  logic [FRAME_BITS-1:0] RX_Data;
  logic                  RX_Data_Valid;
  logic                  RX_Frame_Err;
  logic                  RX_Overrun;

  modport master (
    input  S_Data, RX_Ack,
    output RX_Data, RX_Data_Valid, RX_Frame_Err, RX_Overrun
  );

  modport slave (
    output S_Data, RX_Ack,
    input  RX_Data, RX_Data_Valid, RX_Frame_Err, RX_Overrun
  );

endinterface

// File: rtl/rx_shifter.sv
// Payload shift register with bit down-counter and running parity.
//   clk, rst : clock, synchronous active-high reset
//   load     : arm a new frame (counter = FRAME_BITS-1, parity cleared)
//   shift_en : shift din into the LSB and count down
//   din      : serial input bit
//   data     : shift register contents (first bit ends up in the MSB)
//   done     : last payload bit is being taken this cycle
//   parity   : XOR of all bits shifted since the last load
module rx_shifter
  import rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] data,
  output logic                  done,
  output logic                  parity
);

  logic [FRAME_BITS-1:0] shift_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  par_r;

  // Shift register, counter and parity accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= '0;
      cnt_r   <= '0;
      par_r   <= 1'b0;
    end else if (load) begin
      cnt_r <= CNT_W'(FRAME_BITS - 1);
      par_r <= 1'b0;
    end else if (shift_en) begin
      shift_r <= {shift_r[FRAME_BITS-2:0], din};
      cnt_r   <= cnt_r - CNT_W'(1);
      par_r   <= parity_step(par_r, din);
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
      par_r   <= par_r;
    end
  end

  assign data   = shift_r;
  assign done   = shift_en && (cnt_r == '0);
  assign parity = par_r;

endmodule

// File: rtl/receiver.sv
// Serial-frame receiver: start bit, 55 payload bits MSB first, optional
// even-parity bit, stop bit. Good frames are presented on RX_Data with a
// valid/ack handshake; framing and overrun errors are flagged as pulses.
//   Clk_S : clock
//   Rst   : synchronous active-high reset
//   rx    : receiver_if.master (serial line in, handshake and flags out)
// Optional feature: define RX_PARITY_EN to expect an even-parity bit after
// payload bit 0; without it the frame is start + 55 + stop.
module receiver
  import rx_pkg::*;
(
  input  logic       Clk_S,
  input  logic       Rst,
  receiver_if.master rx
);

  rx_state_t             state_r;
  logic [FRAME_BITS-1:0] data_out_r;
  logic                  valid_r;
  logic                  frame_err_r;
  logic                  overrun_r;

  logic                  load_s;
  logic                  shift_s;
  logic                  done_s;
  logic [FRAME_BITS-1:0] shift_data_s;
  logic                  parity_s;
  logic                  bad_parity_s;
  logic                  stop_ok_s;

  rx_shifter u_shifter (
    .clk      (Clk_S),
    .rst      (Rst),
    .load     (load_s),
    .shift_en (shift_s),
    .din      (rx.S_Data),
    .data     (shift_data_s),
    .done     (done_s),
    .parity   (parity_s)
  );

`ifdef RX_PARITY_EN
  logic par_err_r;
  assign bad_parity_s = par_err_r;
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_s;
  assign bad_parity_s    = 1'b0;
`endif

  assign stop_ok_s = (rx.S_Data == IDLE_LEVEL) && !bad_parity_s;

  // Shifter control decoded from the current state.
  always_comb begin
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx.S_Data != IDLE_LEVEL) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_DATA: shift_s = 1'b1;
      default: begin
        load_s  = 1'b0;
        shift_s = 1'b0;
      end
    endcase
  end

  // Frame FSM, output word register and valid/ack handshake.
  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      state_r     <= ST_IDLE;
      data_out_r  <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef RX_PARITY_EN
      par_err_r   <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      // An ack consumes the word; a load later in this block overrides it.
      if (valid_r && rx.RX_Ack) begin
        valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (rx.S_Data != IDLE_LEVEL) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (done_s) begin
`ifdef RX_PARITY_EN
            state_r <= ST_PARITY;
`else
            state_r <= ST_STOP;
`endif
          end
        end
`ifdef RX_PARITY_EN
        ST_PARITY: begin
          // Even parity: the parity bit must equal the XOR of the payload.
          par_err_r <= rx.S_Data ^ parity_s;
          state_r   <= ST_STOP;
        end
`endif
        ST_STOP: begin
          if (stop_ok_s) begin
            if (!valid_r || rx.RX_Ack) begin
              data_out_r <= shift_data_s;
              valid_r    <= 1'b1;
            end else begin
              overrun_r <= 1'b1;
            end
            state_r <= ST_IDLE;
          end else begin
            frame_err_r <= 1'b1;
            // Only a low stop bit needs the line to recover before re-arming.
            state_r <= (rx.S_Data == IDLE_LEVEL) ? ST_IDLE : ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx.S_Data == IDLE_LEVEL) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign rx.RX_Data       = data_out_r;
  assign rx.RX_Data_Valid = valid_r;
  assign rx.RX_Frame_Err  = frame_err_r;
  assign rx.RX_Overrun    = overrun_r;

endmodule

// File: doc/receiver.md
# receiver

Serial-frame receiver: the far end of the token-router's single-wire link. Samples `S_Data` once per `Clk_S` and detects a start bit. Shifts in a 55-bit payload MSB first and checks the stop bit. Presents the word on `RX_Data` with a valid/ack handshake toward the router core, and flags framing and overrun errors.

## Interface
- `FRAME_BITS`, 55: payload width per frame.
- `Clk_S` in 1: sole clock; every register updates on its rising edge.
- `Rst` in 1: synchronous reset, active-high.
- `S_Data` in 1: serial line; idles high, same clock domain as the transmitter.
- `RX_Ack` in 1: consumer accepts the current `RX_Data`.
- `RX_Data` out 55: last good payload; `RX_Data[54]` is the first bit received.
- `RX_Data_Valid` out 1: high while `RX_Data` is unconsumed.
- `RX_Frame_Err` out 1: one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
- `RX_Overrun` out 1: one-cycle pulse when a good frame is dropped because the previous word is unconsumed.

## Operation
- States: IDLE, DATA, (PARITY), STOP, WAIT_HIGH.
- IDLE:
  - `S_Data`=0 → DATA; bit counter loads `FRAME_BITS`-1.
  - Otherwise stay in IDLE.
  - No glitch filtering: a single low sample is a start bit.
- DATA:
  - Each cycle, shift `S_Data` into the LSB of the 55-bit shift register and decrement the counter.
  - Counter 0 with a bit taken → STOP (or PARITY).
- STOP, sampled `S_Data`=1 (good frame):
  - If `RX_Data_Valid`=0, or `RX_Ack`=1 this cycle: load `RX_Data` from the shift register and set `RX_Data_Valid`=1.
  - Otherwise: keep the old `RX_Data`, drop the new frame and pulse `RX_Overrun`.
  - Go to IDLE.
- STOP, sampled `S_Data`=0: pulse `RX_Frame_Err`, do not load, go to WAIT_HIGH.
- WAIT_HIGH: stay until `S_Data`=1, then go to IDLE. This prevents a stuck-low line from producing back-to-back frames.
- Handshake:
  - `RX_Ack` while `RX_Data_Valid`=1 clears valid the next cycle.
  - `RX_Ack` while valid is low is ignored.
  - If a load and an ack occur in the same cycle, valid stays 1 with the new data.
- `RX_Data` is updated only on a good load. It is stable while valid is high.
- Reset values: all outputs 0, shift register 0, state IDLE. Reset mid-frame discards the partial frame with no error pulse.

## Timing
- Start bit sampled at cycle t.
- Data bits sampled at t+1 … t+55, bit 54 first.
- Stop bit sampled at t+56.
- At t+57, one of the following is visible:
  - `RX_Data_Valid` rises with `RX_Data` loaded, or
  - the `RX_Overrun` pulse, or
  - the `RX_Frame_Err` pulse.
- A following start bit is accepted as early as t+57 (zero idle gap).
- With parity enabled, every post-data offset shifts by one cycle: parity at t+56, stop at t+57, result at t+58.
- Error pulses last exactly one cycle. `RX_Data_Valid` is a level.

## Configuration
- `RX_PARITY_EN` defined:
  - An even-parity bit follows bit 0.
  - A mismatch pulses `RX_Frame_Err` at the stop-result cycle (same cycle as a stop error) and the frame is not loaded.
  - A parity mismatch with a good stop bit returns to IDLE, not WAIT_HIGH.
- `RX_PARITY_EN` undefined: no PARITY state; the frame is start + 55 + stop, matching the current transmitter. This is the default build.

## Structure
- Package `rx_pkg`:
  - state enum `rx_state_t`
  - `FRAME_BITS`=55
  - `CNT_W`=6
  - `IDLE_LEVEL`=1'b1
- Sub-module `rx_shifter`: 55-bit shift register plus down-counter with shift-enable, load and `done` outputs, and a running parity bit.
- Top `receiver`: holds the FSM, the output register and the handshake logic.

## Test plan
- Single frame, payload 55'h2A_AAAA_AAAA_AAAA (alternating bits), stop=1 → `RX_Data`=55'h2A_AAAA_AAAA_AAAA and `RX_Data_Valid`=1 at t+57; `RX_Ack` one cycle later → valid=0 the next cycle.
- Back-to-back frames: 55'h1 then 55'h7F_FFFF_FFFF_FFFF with 0 idle cycles, `RX_Ack` pulsed at t+57 → both words delivered, no overrun.
- Second good frame completes while the first is unacked → `RX_Overrun` pulses once; `RX_Data` holds the first value; valid stays 1.
- Stop bit driven 0 and the line held low 10 cycles → `RX_Frame_Err` pulses once; no valid; no new start is detected until `S_Data` returns high.
- `Rst` asserted at bit 30 of a frame → next cycle all outputs are 0 and state is IDLE; the next complete frame is received correctly.
- `RX_PARITY_EN` build: payload 55'h3 with parity bit 1 (mismatch) → `RX_Frame_Err` at t+58, no load; with parity bit 0 → valid at t+58.
